btn_counter_ctrl: RTL and testbench

Parametrised button-driven up/down counter with per-button synchronisation, debounce, and hold-to-auto-repeat, driving a WIDTH-bit LED bank. It replaces the single-button, fixed 8-bit, free-running hold counter with three buttons (up, down, clear), configurable timing, wrap or saturate mode, and selectable LED polarity. It sits at board top level between the raw pushbuttons and the LED pins.

---
 rtl/btn_counter_ctrl.sv | 139 +++++++++++++
 tb/tb_btn_counter_ctrl.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/btn_counter_ctrl.sv
// Three-button up/down/clear counter: 2-flop sync, per-button debounce,
// hold-to-auto-repeat FSM, wrap or saturate arithmetic, LED polarity select.
module btn_counter_ctrl #(
    parameter int WIDTH           = 8,
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int HOLD_CYCLES     = 12500000,
    parameter int REPEAT_CYCLES   = 3125000,
    parameter int SATURATE        = 0,
    parameter int LED_ACTIVE_LOW  = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             btn_up,
    input  logic             btn_down,
    input  logic             btn_clr,
    output logic [WIDTH-1:0] count,
    output logic [WIDTH-1:0] led,
    output logic             step
);

    localparam int MAX_DH = (DEBOUNCE_CYCLES > HOLD_CYCLES) ? DEBOUNCE_CYCLES : HOLD_CYCLES;
    localparam int MAX_C  = (MAX_DH > REPEAT_CYCLES) ? MAX_DH : REPEAT_CYCLES;
    localparam int TW     = (MAX_C < 1) ? 1 : $clog2(MAX_C + 1);

    typedef enum logic [1:0] {IDLE, HOLD, REPEAT} state_t;
    typedef enum logic [1:0] {CMD_NONE, CMD_UP, CMD_DN, CMD_CLR} cmd_t;

    // Bit order everywhere: [0]=up, [1]=down, [2]=clr
    logic [2:0]    raw, sync1, sync2, deb, deb_q, rise;
    logic [TW-1:0] deb_cnt [3];

    state_t        state, state_nxt;
    cmd_t          cmd, dir, dir_nxt;
    logic [TW-1:0] timer, timer_nxt;
    logic [WIDTH-1:0] count_nxt;
    logic          do_up, do_dn, do_clr;

    assign raw  = {btn_clr, btn_down, btn_up};
    assign rise = deb & ~deb_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1 <= '0;
            sync2 <= '0;
            deb   <= '0;
            deb_q <= '0;
            for (int unsigned i = 0; i < 3; i++) deb_cnt[i] <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            deb_q <= deb;
            for (int unsigned i = 0; i < 3; i++) begin
                if (sync2[i] != deb[i]) begin
                    if (deb_cnt[i] == TW'(DEBOUNCE_CYCLES - 1)) begin
                        deb[i]     <= sync2[i];
                        deb_cnt[i] <= '0;
                    end else begin
                        deb_cnt[i] <= deb_cnt[i] + TW'(1);
                    end
                end else begin
                    deb_cnt[i] <= '0;
                end
            end
        end
    end

    always_comb begin
        cmd = CMD_NONE;
        if (deb[2])
            cmd = CMD_CLR;
        else if (deb[0] ^ deb[1])
            cmd = deb[0] ? CMD_UP : CMD_DN;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            dir   <= CMD_NONE;
            timer <= '0;
            count <= '0;
            step  <= 1'b0;
        end else begin
            state <= state_nxt;
            dir   <= dir_nxt;
            timer <= timer_nxt;
            count <= count_nxt;
            step  <= (count_nxt != count);
        end
    end

    always_comb begin
        state_nxt = state;
        dir_nxt   = dir;
        timer_nxt = timer;
        do_up     = 1'b0;
        do_dn     = 1'b0;
        do_clr    = rise[2];
        unique case (state)
            IDLE: begin
                if ((cmd == CMD_UP && rise[0]) || (cmd == CMD_DN && rise[1])) begin
                    do_up     = (cmd == CMD_UP);
                    do_dn     = (cmd == CMD_DN);
                    dir_nxt   = cmd;
                    timer_nxt = TW'(HOLD_CYCLES - 1);
                    state_nxt = HOLD;
                end
            end
            HOLD, REPEAT: begin
                // Any change of command (NONE, other direction, clear) aborts the press
                if (cmd != dir) begin
                    state_nxt = IDLE;
                    dir_nxt   = CMD_NONE;
                end else if (timer == '0) begin
                    do_up     = (dir == CMD_UP);
                    do_dn     = (dir == CMD_DN);
                    timer_nxt = TW'(REPEAT_CYCLES - 1);
                    state_nxt = REPEAT;
                end else begin
                    timer_nxt = timer - TW'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        count_nxt = count;
        if (do_clr) begin
            count_nxt = '0;
        end else if (do_up) begin
            if (!(SATURATE != 0 && count == '1)) count_nxt = count + WIDTH'(1);
        end else if (do_dn) begin
            if (!(SATURATE != 0 && count == '0)) count_nxt = count - WIDTH'(1);
        end
    end

    assign led = (LED_ACTIVE_LOW != 0) ? ~count : count;

endmodule

// File: tb/tb_btn_counter_ctrl.sv
// Self-checking bench: wrap/active-low and saturate/active-high instances
// driven together and compared every cycle against a press-age reference model.
module tb_btn_counter_ctrl;

    localparam int W    = 4;
    localparam int DEB  = 4;
    localparam int HOLD = 20;
    localparam int REP  = 5;

    logic clk = 1'b0, rst_n = 1'b0, up = 1'b0, dn = 1'b0, clr = 1'b0;
    logic [W-1:0] count_w, led_w, count_s, led_s;
    logic step_w, step_s;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    btn_counter_ctrl #(.WIDTH(W), .DEBOUNCE_CYCLES(DEB), .HOLD_CYCLES(HOLD),
                       .REPEAT_CYCLES(REP), .SATURATE(0), .LED_ACTIVE_LOW(1)) dut_w (
        .clk(clk), .rst_n(rst_n), .btn_up(up), .btn_down(dn), .btn_clr(clr),
        .count(count_w), .led(led_w), .step(step_w));

    btn_counter_ctrl #(.WIDTH(W), .DEBOUNCE_CYCLES(DEB), .HOLD_CYCLES(HOLD),
                       .REPEAT_CYCLES(REP), .SATURATE(1), .LED_ACTIVE_LOW(0)) dut_s (
        .clk(clk), .rst_n(rst_n), .btn_up(up), .btn_down(dn), .btn_clr(clr),
        .count(count_s), .led(led_s), .step(step_s));

    // Reference model: sync is a 2-sample delay, debounce is a run length of
    // disagreement, and steps fall at press ages 0, HOLD, HOLD+k*REP.
    bit [2:0] m_s1, m_s2, m_deb, m_debq;
    int m_run [3];
    int m_cnt_w, m_cnt_s, held, age;
    bit m_step_w, m_step_s;

    function automatic int wrap_add(int c, int d);
        return (c + d + 16) % 16;
    endfunction

    function automatic int sat_add(int c, int d);
        int v;
        v = c + d;
        if (v < 0) v = 0;
        if (v > 15) v = 15;
        return v;
    endfunction

    task automatic model_edge(input bit r, input bit [2:0] b);
        int dirn, nw, ns;
        bit is_clr;
        bit [2:0] rs;
        if (!r) begin
            m_s1 = '0; m_s2 = '0; m_deb = '0; m_debq = '0;
            for (int i = 0; i < 3; i++) m_run[i] = 0;
            m_cnt_w = 0; m_cnt_s = 0; m_step_w = 0; m_step_s = 0;
            held = 0; age = 0;
            return;
        end
        is_clr = m_deb[2];
        dirn = 0;
        if (!is_clr && m_deb[0] && !m_deb[1]) dirn = 1;
        if (!is_clr && m_deb[1] && !m_deb[0]) dirn = -1;
        rs = m_deb & ~m_debq;
        nw = m_cnt_w;
        ns = m_cnt_s;
        if (rs[2]) begin nw = 0; ns = 0; end
        if (held != 0) begin
            if (dirn != held) held = 0;
            else begin
                age++;
                if (age >= HOLD && (age - HOLD) % REP == 0) begin
                    nw = wrap_add(nw, held);
                    ns = sat_add(ns, held);
                end
            end
        end else if ((dirn == 1 && rs[0]) || (dirn == -1 && rs[1])) begin
            nw = wrap_add(nw, dirn);
            ns = sat_add(ns, dirn);
            held = dirn;
            age = 0;
        end
        m_step_w = (nw != m_cnt_w);
        m_step_s = (ns != m_cnt_s);
        m_cnt_w = nw;
        m_cnt_s = ns;
        m_debq = m_deb;
        for (int i = 0; i < 3; i++) begin
            if (m_s2[i] != m_deb[i]) begin
                m_run[i]++;
                if (m_run[i] == DEB) begin m_deb[i] = m_s2[i]; m_run[i] = 0; end
            end else m_run[i] = 0;
        end
        m_s2 = m_s1;
        m_s1 = b;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        bit r;
        bit [2:0] b;
        r = rst_n;
        b = {clr, dn, up};
        @(posedge clk);
        model_edge(r, b);
        #1;
        chk("count_wrap", {28'b0, count_w}, m_cnt_w);
        chk("led_wrap",   {28'b0, led_w},   m_cnt_w ^ 15);
        chk("step_wrap",  {31'b0, step_w},  {31'b0, m_step_w});
        chk("count_sat",  {28'b0, count_s}, m_cnt_s);
        chk("led_sat",    {28'b0, led_s},   m_cnt_s);
        chk("step_sat",   {31'b0, step_s},  {31'b0, m_step_s});
    endtask

    task automatic hold(input bit [2:0] m, input int n);
        {clr, dn, up} = m;
        repeat (n) tick();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        hold(3'b000, 2);
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        // Reset with up held, then first step exactly 7 edges after release
        rst_n = 1'b0;
        up = 1'b1;
        repeat (3) begin
            tick();
            chk("rst_count", {28'b0, count_w}, 0);
            chk("rst_led",   {28'b0, led_w},   32'hF);
            chk("rst_step",  {31'b0, step_w},  0);
        end
        rst_n = 1'b1;
        for (int i = 1; i <= 7; i++) begin
            tick();
            chk("post_rst_count", {28'b0, count_w}, (i < 7) ? 0 : 1);
            chk("post_rst_step",  {31'b0, step_w},  (i < 7) ? 0 : 1);
        end
        hold(3'b000, 15);

        // Bounce rejection, then one clean press
        do_reset();
        repeat (5) begin
            hold(3'b001, 3);
            hold(3'b000, 1);
        end
        hold(3'b000, 10);
        chk("bounce_count", {28'b0, count_w}, 0);
        hold(3'b001, 10);
        hold(3'b000, 15);
        chk("clean_count", {28'b0, count_w}, 1);

        // Auto-repeat: steps at ages 0,20,25..55
        do_reset();
        hold(3'b001, 60);
        hold(3'b000, 40);
        chk("repeat_count_w", {28'b0, count_w}, 9);
        chk("repeat_count_s", {28'b0, count_s}, 9);

        // Upper and lower bounds
        do_reset();
        hold(3'b001, 88);
        hold(3'b000, 20);
        chk("to15_w", {28'b0, count_w}, 15);
        chk("to15_s", {28'b0, count_s}, 15);
        hold(3'b001, 10);
        hold(3'b000, 15);
        chk("up_wrap", {28'b0, count_w}, 0);
        chk("up_sat",  {28'b0, count_s}, 15);
        do_reset();
        hold(3'b010, 10);
        hold(3'b000, 15);
        chk("dn_wrap", {28'b0, count_w}, 15);
        chk("dn_sat",  {28'b0, count_s}, 0);

        // Conflicting directions
        do_reset();
        hold(3'b001, 30);
        hold(3'b011, 20);
        hold(3'b010, 20);
        chk("conflict_held", {28'b0, count_w}, 3);
        hold(3'b000, 10);
        hold(3'b010, 10);
        hold(3'b000, 15);
        chk("conflict_repress", {28'b0, count_w}, 2);

        // Clear while up held
        do_reset();
        repeat (7) begin
            hold(3'b001, 10);
            hold(3'b000, 10);
        end
        chk("clr_pre", {28'b0, count_w}, 7);
        hold(3'b101, 30);
        chk("clr_done", {28'b0, count_w}, 0);
        hold(3'b001, 30);
        chk("clr_up_ignored", {28'b0, count_w}, 0);
        hold(3'b000, 15);
        hold(3'b001, 10);
        hold(3'b000, 15);
        chk("clr_repress", {28'b0, count_w}, 1);

        // Random button activity with occasional resets
        repeat (80) begin
            rst_n = ($urandom_range(0, 15) != 0);
            hold(3'($urandom_range(0, 7)), $urandom_range(1, 30));
        end
        rst_n = 1'b1;
        hold(3'b000, 20);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
